// File: rtl/pwm_multi_channel_pkg.sv
// Shared types and sizing helpers for the multi-channel PWM generator.
// Centre-aligned counting is compiled in only when PWM_CENTER_ALIGN_EN is defined.
package pwm_multi_channel_pkg;

    typedef enum logic {
        MODE_EDGE   = 1'b0,
        MODE_CENTER = 1'b1
    } pwm_mode_e;

    // One extra address bit so out-of-range channel indices are representable.
    function automatic int pwm_addr_w(input int num_ch);
        return $clog2(num_ch) + 1;
    endfunction

    function automatic int pwm_max(input int cw);
        return (1 << cw) - 1;
    endfunction

endpackage

// File: rtl/pwm_multi_channel_timebase.sv
// Shared timebase: clk_in synchroniser, prescaler, counter and period boundary.
// With PWM_CENTER_ALIGN_EN defined the counter can run up/down; otherwise edge mode only.
module pwm_multi_channel_timebase
    import pwm_multi_channel_pkg::*;
#(
    parameter int COMPARE_SIZE  = 8,
    parameter int PRESCALE_SIZE = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clk_in_i,
    input  logic                     use_sys_i,
    input  logic [PRESCALE_SIZE-1:0] prescale_i,
    input  logic                     center_mode_i,
    output logic [COMPARE_SIZE-1:0]  cnt_o,
    output logic                     boundary_o
);

    localparam logic [COMPARE_SIZE-1:0] CMP_MAX = COMPARE_SIZE'(pwm_max(COMPARE_SIZE));

    // [1:0] is the two-flop synchroniser, [2] holds the previous synced level.
    logic [2:0]               sync_q;
    logic [PRESCALE_SIZE-1:0] psc_q, psc_d;
    logic [COMPARE_SIZE-1:0]  cnt_q, cnt_d;
    logic                     tick, step, bnd;

    assign tick = use_sys_i | (sync_q[1] & ~sync_q[2]);
    assign step = tick && (psc_q == prescale_i);

    always_comb begin
        psc_d = psc_q;
        if (tick) psc_d = step ? '0 : psc_q + 1'b1;
    end

`ifdef PWM_CENTER_ALIGN_EN
    pwm_mode_e mode_q, mode_d;
    logic      dir_q, dir_d;   // 1 = counting down

    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        mode_d = mode_q;
        bnd    = 1'b0;
        if (step) begin
            if (mode_q == MODE_CENTER) begin
                if (dir_q) begin
                    if (cnt_q == '0) begin
                        bnd   = 1'b1;
                        cnt_d = COMPARE_SIZE'(1);
                        dir_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end else if (cnt_q == CMP_MAX) begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
                dir_d = 1'b0;
                bnd   = (cnt_q == CMP_MAX);
            end
            // Mode only changes between periods so no period is ever split.
            if (bnd) mode_d = center_mode_i ? MODE_CENTER : MODE_EDGE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= MODE_EDGE;
            dir_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end
`else
    logic unused_center;
    assign unused_center = center_mode_i;

    always_comb begin
        cnt_d = cnt_q;
        bnd   = 1'b0;
        if (step) begin
            cnt_d = cnt_q + 1'b1;
            bnd   = (cnt_q == CMP_MAX);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            psc_q  <= '0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[1:0], clk_in_i};
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign boundary_o = bnd;

endmodule

// File: rtl/pwm_multi_channel.sv
// NUM_CH-channel PWM with double-buffered compares applied at period boundaries.
// Define PWM_CENTER_ALIGN_EN to honour center_mode_i (up/down counting).
module pwm_multi_channel
    import pwm_multi_channel_pkg::*;
#(
    parameter int NUM_CH        = 4,
    parameter int COMPARE_SIZE  = 8,
    parameter int PRESCALE_SIZE = 8
) (
    input  logic                          sys_clk_i,
    input  logic                          rst_i,
    input  logic                          clk_in_i,
    input  logic                          use_sys_i,
    input  logic [PRESCALE_SIZE-1:0]      prescale_i,
    input  logic                          center_mode_i,
    input  logic                          wr_i,
    input  logic [pwm_addr_w(NUM_CH)-1:0] wr_addr_i,
    input  logic [COMPARE_SIZE-1:0]       wr_data_i,
    input  logic [NUM_CH-1:0]             ena_i,
    output logic [NUM_CH-1:0]             pwm_out_o,
    output logic                          period_start_o
);

    localparam int                      ADDR_W   = pwm_addr_w(NUM_CH);
    localparam logic [ADDR_W-1:0]       NUM_CH_A = ADDR_W'(NUM_CH);
    localparam logic [COMPARE_SIZE-1:0] CMP_MAX  = COMPARE_SIZE'(pwm_max(COMPARE_SIZE));

    logic [COMPARE_SIZE-1:0]             cnt;
    logic                                boundary;
    logic                                wr_q, wr_hit;
    logic [NUM_CH-1:0]                   wr_sel;
    logic [NUM_CH-1:0][COMPARE_SIZE-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [NUM_CH-1:0]                   pending_q, pending_d, armed_q, armed_d;
    logic [NUM_CH-1:0]                   pwm_q, pwm_d;
    logic                                period_start_q;

    pwm_multi_channel_timebase #(
        .COMPARE_SIZE  (COMPARE_SIZE),
        .PRESCALE_SIZE (PRESCALE_SIZE)
    ) u_timebase (
        .clk_i         (sys_clk_i),
        .rst_i         (rst_i),
        .clk_in_i      (clk_in_i),
        .use_sys_i     (use_sys_i),
        .prescale_i    (prescale_i),
        .center_mode_i (center_mode_i),
        .cnt_o         (cnt),
        .boundary_o    (boundary)
    );

    // A held strobe produces exactly one write.
    assign wr_hit = wr_i && !wr_q && (wr_addr_i < NUM_CH_A);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr_sel[g]    = wr_hit && (wr_addr_i == ADDR_W'(g));
        // Boundary transfer uses the pre-write shadow; a same-cycle write stays pending.
        assign active_d[g]  = (boundary && pending_q[g]) ? shadow_q[g] : active_q[g];
        assign shadow_d[g]  = wr_sel[g] ? wr_data_i : shadow_q[g];
        assign pending_d[g] = wr_sel[g] | (pending_q[g] & ~boundary);
        assign armed_d[g]   = ena_i[g] & (armed_q[g] | boundary);
        assign pwm_d[g]     = armed_q[g] & ena_i[g] &
                              ((active_q[g] == CMP_MAX) | (cnt < active_q[g]));
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            wr_q           <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
            pending_q      <= '0;
            armed_q        <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            wr_q           <= wr_i;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            armed_q        <= armed_d;
            pwm_q          <= pwm_d;
            period_start_q <= boundary;
        end
    end

    assign pwm_out_o      = pwm_q;
    assign period_start_o = period_start_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Directed + random bench for pwm_multi_channel against an arithmetic reference model.
// Centre-mode checks are active when PWM_CENTER_ALIGN_EN is defined.
module tb_pwm_multi_channel;

    localparam int NCH = 4;
    localparam int CW  = 8;
    localparam int PW  = 8;
    localparam int AW  = 3;

    logic           clk = 1'b0;
    logic           rst, clk_in, use_sys, center_mode, wr;
    logic [PW-1:0]  prescale;
    logic [AW-1:0]  wr_addr;
    logic [CW-1:0]  wr_data;
    logic [NCH-1:0] ena, pwm_out;
    logic           period_start;

    always #5 clk = ~clk;

    pwm_multi_channel #(.NUM_CH(NCH), .COMPARE_SIZE(CW), .PRESCALE_SIZE(PW)) dut (
        .sys_clk_i      (clk),
        .rst_i          (rst),
        .clk_in_i       (clk_in),
        .use_sys_i      (use_sys),
        .prescale_i     (prescale),
        .center_mode_i  (center_mode),
        .wr_i           (wr),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .ena_i          (ena),
        .pwm_out_o      (pwm_out),
        .period_start_o (period_start)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: counter position derived from total step count.
    int             m_ticks, m_steps;
    logic [CW-1:0]  m_shadow [NCH];
    logic [CW-1:0]  m_active [NCH];
    bit             m_pend   [NCH];
    bit             m_armed  [NCH];
    bit             m_wrq, model_on, m_center, clk_gen;
    logic [NCH-1:0] exp_pwm;
    logic           exp_ps;
    int             clk_div;
    int             m_hi [NCH];

    function automatic int cnt_of(input int s);
        int u, r;
        if (!m_center || s <= 256) return s % 256;
        u = s - 256;
        r = u % 510;
        if (r == 0) return 0;
        if (r <= 255) return r;
        return 510 - r;
    endfunction

    function automatic bit is_bnd(input int s);
        int u;
        if (!m_center || s <= 256) return (s > 0) && (s % 256 == 0);
        u = s - 256;
        return (u >= 511) && (u % 510 == 1);
    endfunction

    task automatic model_step();
        int  pre;
        bit  b;
        if (rst) begin
            m_ticks = 0; m_steps = 0; m_wrq = 0;
            for (int c = 0; c < NCH; c++) begin
                m_shadow[c] = '0; m_active[c] = '0; m_pend[c] = 0; m_armed[c] = 0;
            end
            exp_pwm = '0; exp_ps = 1'b0;
            return;
        end
        pre = cnt_of(m_steps);
        for (int c = 0; c < NCH; c++)
            exp_pwm[c] = m_armed[c] && ena[c] &&
                         (int'(m_active[c]) == 255 || pre < int'(m_active[c]));
        b = 0;
        m_ticks++;
        if (m_ticks % (int'(prescale) + 1) == 0) begin
            m_steps++;
            b = is_bnd(m_steps);
        end
        exp_ps = b;
        for (int c = 0; c < NCH; c++) begin
            if (b && m_pend[c]) begin m_active[c] = m_shadow[c]; m_pend[c] = 0; end
            m_armed[c] = ena[c] && (m_armed[c] || b);
        end
        if (wr && !m_wrq && int'(wr_addr) < NCH) begin
            m_shadow[int'(wr_addr)] = wr_data;
            m_pend[int'(wr_addr)]   = 1;
        end
        m_wrq = wr;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (model_on) model_step();
        @(negedge clk);
        if (model_on) begin
            chk("pwm_cycle", 32'(pwm_out), 32'(exp_pwm));
            chk("ps_cycle", 32'(period_start), 32'(exp_ps));
        end
        if (clk_gen) begin
            clk_div++;
            if (clk_div == 4) begin clk_div = 0; clk_in = ~clk_in; end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
    endtask

    task automatic write(input int a, input int d);
        wr_addr = AW'(a); wr_data = CW'(d); wr = 1'b1; cyc();
        wr = 1'b0; cyc();
    endtask

    task automatic wait_ps(input int limit);
        int n = 0;
        bit seen = 0;
        while (!seen && n < limit) begin cyc(); n++; seen = period_start; end
        chk("ps_seen", 32'(seen), 32'd1);
    endtask

    // Counts samples up to and including the next period_start pulse.
    task automatic measure(input int limit, output int len);
        bit seen = 0;
        len = 0;
        for (int c = 0; c < NCH; c++) m_hi[c] = 0;
        while (!seen && len < limit) begin
            cyc(); len++;
            for (int c = 0; c < NCH; c++) m_hi[c] += int'(pwm_out[c]);
            seen = period_start;
        end
    endtask

    task automatic count_high(input int ch, input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin cyc(); cnt += int'(pwm_out[ch]); end
    endtask

    initial begin
        int len, c1, c2, d;
        rst = 1'b1; clk_in = 1'b0; use_sys = 1'b1; prescale = '0; center_mode = 1'b0;
        wr = 1'b0; wr_addr = '0; wr_data = '0; ena = '0;
        model_on = 1; m_center = 0; clk_gen = 0; clk_div = 0;

        do_reset();
        chk("rst_pwm", 32'(pwm_out), 32'd0);
        chk("rst_ps", 32'(period_start), 32'd0);

        // 64/256 duty on ch0
        write(0, 64); ena = 4'b0001;
        wait_ps(300); wait_ps(300);
        measure(300, len);
        chk("t1_len", 32'(len), 32'd256);
        chk("t1_duty", 32'(m_hi[0]), 32'd64);

        // mid-period compare change takes effect at the next boundary only
        write(1, 50); ena = 4'b0011;
        wait_ps(300); wait_ps(300);
        count_high(1, 100, c1);
        write(1, 200);
        count_high(1, 154, c2);
        chk("t2_old_duty", 32'(c1 + c2), 32'd50);
        measure(300, len);
        chk("t2_new_duty", 32'(m_hi[1]), 32'd200);

        // held strobe captures only the first value; out-of-range address ignored
        wr_addr = 3'd0; wr = 1'b1;
        for (int i = 0; i < 10; i++) begin wr_data = CW'(30 + i * 7); cyc(); end
        wr = 1'b0; cyc();
        write(4, 99);
        wait_ps(300);
        measure(300, len);
        chk("t3_first_only", 32'(m_hi[0]), 32'd30);
        chk("t3_addr_oob", 32'(m_hi[1]), 32'd200);

        // 0% and 100% extremes, enable drop and rearm
        write(2, 0); write(3, 255); ena = 4'b1111;
        wait_ps(300);
        measure(300, len);
        chk("t4_zero", 32'(m_hi[2]), 32'd0);
        chk("t4_full", 32'(m_hi[3]), 32'd256);
        count_high(3, 20, c1);
        ena[3] = 1'b0; cyc();
        chk("t4_ena_drop", 32'(pwm_out[3]), 32'd0);
        ena[3] = 1'b1;
        measure(300, len);
        chk("t4_no_partial", 32'(m_hi[3]), 32'd0);
        measure(300, len);
        chk("t4_rearm", 32'(m_hi[3]), 32'd256);

        // randomised traffic with prescale, including a mid-run reset
        prescale = 8'd1;
        do_reset();
        ena = NCH'($urandom);
        for (int i = 0; i < 4000; i++) begin
            wr      = ($urandom_range(0, 3) == 0);
            wr_addr = AW'($urandom_range(0, 5));
            d       = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 0 : 255;
            wr_data = CW'(d);
            if ($urandom_range(0, 63) == 0) ena[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if (i == 2000) begin
                rst = 1'b1; cyc(); rst = 1'b0;
                chk("rand_rst_pwm", 32'(pwm_out), 32'd0);
                chk("rand_rst_ps", 32'(period_start), 32'd0);
            end else begin
                cyc();
            end
        end
        wr = 1'b0;

        // external clock: 8-cycle clk_in, prescale 3 -> 8192-cycle period
        model_on = 0; use_sys = 1'b0; prescale = 8'd3; clk_gen = 1; clk_div = 0;
        do_reset();
        wait_ps(20000);
        measure(9000, len);
        chk("t5_period", 32'(len), 32'd8192);
        clk_gen = 0; use_sys = 1'b1; prescale = '0;

        // centre mode (ignored unless compiled in)
        model_on = 1; center_mode = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
        m_center = 1;
`endif
        do_reset();
        write(0, 128); ena = 4'b0001;
        wait_ps(300);
`ifdef PWM_CENTER_ALIGN_EN
        wait_ps(600);
        measure(600, len);
        chk("t6_center_len", 32'(len), 32'd510);
        chk("t6_center_duty", 32'(m_hi[0]), 32'd255);
`else
        measure(300, len);
        chk("t6_edge_len", 32'(len), 32'd256);
        chk("t6_edge_duty", 32'(m_hi[0]), 32'd128);
`endif
        count_high(0, 100, c1);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("t6_rst_pwm", 32'(pwm_out), 32'd0);
        chk("t6_rst_ps", 32'(period_start), 32'd0);
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
